shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Parametrised sequential multiplier and the successor to the combinational 2x2 array multiplier. It multiplies two `W`-bit operands, either unsigned or two's-complement, using one shift-add iteration per clock. Operands are captured through a start/done handshake, so arithmetic cost is one `W`-bit adder regardless of width. It sits beside the existing dataflow arithmetic blocks wherever a wide product is needed and a few cycles of latency are acceptable.

## Interface
- `W`, default 8: operand width, legal range 2 to 32. The product is `2W` bits.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a multiply. Accepted only in IDLE.
- `signed_mode`  in  1: 1 treats `a` and `b` as two's complement, 0 treats them as unsigned. Sampled on accept.
- `a`  in  `W`: multiplicand. Sampled on accept.
- `b`  in  `W`: multiplier. Sampled on accept.
- `busy`  out  1: high while the state is RUN or DONE.
- `done`  out  1: one-cycle pulse that marks `p` as updated.
- `p`  out  `2W`: product. Held until the next completion.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:** `rst_n` low forces state to IDLE immediately. `busy`=0, `done`=0, `p`=0, and all internal registers are cleared.
- **IDLE:** on `start`=1 at an edge:
  - Latch `mcand` = |a| and `mplier` = |b|. Take the magnitude only when `signed_mode`=1 and the MSB is set; otherwise use the raw value.
  - Latch `neg` = `signed_mode` & (a[W-1] ^ b[W-1]).
  - Clear the `2W`-bit accumulator and the iteration counter.
  - Go to RUN.
- **Magnitude of the most negative value:** |−2^(W−1)| = 2^(W−1) fits in `W` unsigned bits. No special case is needed.
- **RUN, each edge:**
  - If mplier[0]=1, add mcand to acc[2W−1:W] with the carry kept.
  - Shift {carry, acc} right by 1, filling from mplier[0] in the standard shift-add arrangement.
  - Shift `mplier` right by 1 and increment the counter.
  - After exactly `W` iterations, go to DONE.
- **DONE, one edge:**
  - `p` ← `neg` ? (−acc mod 2^(2W)) : acc.
  - `done` ← 1.
  - Go to IDLE.
- **Holding:** `done` is 0 on every other edge. `p` keeps its value until the next DONE.
- **Ignored requests:** `start` is ignored in RUN and DONE. It is not queued.
- **Operand stability:** changes on `a`, `b` or `signed_mode` after acceptance have no effect on the product in flight.
- **Range:** the signed product always fits in `2W` bits, including (−2^(W−1))² = 2^(2W−2). No overflow flag is provided.

## Timing
- **Latency:** with `start` accepted at edge k:
  - `busy` is high after edge k.
  - RUN occupies edges k+1 … k+W.
  - `p` and `done` update at edge k+W+1.
  - `busy` falls at edge k+W+1.
  - Total latency is W+1 cycles from accept to `done`.
- **Back-to-back:** `start` is accepted in the cycle where `done`=1, because the state is already IDLE. Throughput is one product per W+2 cycles.
- **Reset mid-operation:** the result is discarded. `p` reads 0. The next `start` after `rst_n` rises behaves as from power-up.
- **Reset and start together:** `start` asserted in the same cycle that `rst_n` deasserts is accepted at the first rising edge with `rst_n`=1.
- **Registered outputs:** all outputs come directly from flops. There is no combinational path from inputs to outputs.

## Test plan
- **W=2 exhaustive, unsigned:** all 16 (a,b) pairs → `p`=a·b, e.g. 3×3 → 4'b1001, with `done` exactly 3 cycles after accept.
- **W=8 unsigned corners:**
  - 255×255 → 16'hFE01.
  - 0×200 → 0.
  - 1×128 → 16'h0080.
- **W=8 signed:**
  - −3×5 → 16'hFFF1.
  - −128×−128 → 16'h4000.
  - −128×127 → 16'hC080.
  - 7×−1 → 16'hFFF9.
- **Start while busy:** pulse `start` with new operands at accept+3 → ignored, and the first product is unchanged. A re-issue in the `done` cycle is accepted and completes W+1 cycles later.
- **Reset mid-RUN:** drop `rst_n` at accept+4 → `busy`=0 and `p`=0 immediately, no `done` pulse, then a fresh 12×12 → 144.
- **Random regression:** random W∈{4,8,16}, random operands and modes, 10k ops → match against the reference-model product, `done` pulses exactly once per accepted `start`, and `busy` never high in IDLE.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential W x W multiplier, one shift-add step per clock, unsigned or two's-complement.
// Operands are taken as magnitudes on accept; the sign is re-applied once when the product is published.
module shift_add_multiplier #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   p,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE; done is a single-cycle pulse marking p as fresh.
  state_t          state, state_next;
  logic [W-1:0]    mcand, mplier;
  logic [W-1:0]    a_mag, b_mag;
  logic            neg;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic [W:0]      sum;

  // |-(2^(W-1))| wraps back to 2^(W-1), which is the correct unsigned magnitude.
  assign a_mag = (signed_mode && a[W-1]) ? -a : a;
  assign b_mag = (signed_mode && b[W-1]) ? -b : b;

  assign sum = {1'b0, acc[2*W-1:W]} + {1'b0, (mplier[0] ? mcand : {W{1'b0}})};

  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CW'(W-1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mode & (a[W-1] ^ b[W-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          // Carry out of the upper-half add becomes the new MSB as the accumulator shifts right.
          acc    <= {sum, acc[W-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          p    <= neg ? -acc : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: W=2 exhaustive unsigned, W=8 corners, signed,
// start-while-busy, back-to-back re-issue, reset mid-run and a short random sweep.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start2, sm2, busy2, done2;
  logic [1:0]  a2, b2, st2;
  logic [3:0]  p2;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [1:0]  st8;
  logic [15:0] p8;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [7:0]  TA [8] = '{8'hFF, 8'h00, 8'h01, 8'hFD, 8'h80, 8'h80, 8'h07, 8'h64};
  localparam logic [7:0]  TB [8] = '{8'hFF, 8'hC8, 8'h80, 8'h05, 8'h80, 8'h7F, 8'hFF, 8'h64};
  localparam logic        TS [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [15:0] TE [8] = '{16'hFE01, 16'h0000, 16'h0080, 16'hFFF1,
                                     16'h4000, 16'hC080, 16'hFFF9, 16'h2710};

  shift_add_multiplier #(.W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .p(p2), .dbg_state(st2)
  );

  shift_add_multiplier #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8), .dbg_state(st8)
  );

  // Driver: issue one request, scramble operands after accept, wait (bounded) for done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      output logic [15:0] prod, output int lat, output logic acc_busy,
                      output int busy_lo);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; sm8 = ~sm;
    acc_busy = busy8; lat = 0; busy_lo = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!done8 && !busy8) busy_lo++;
    end
    prod = p8;
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b,
                      output logic [3:0] prod, output int lat);
    @(negedge clk);
    a2 = a; b2 = b; sm2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = ~a; b2 = ~b;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = p2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done8); end
    n_vec++; if (p8 !== 16'h0000) begin n_err++; $display("FAIL reset_p8 got=%h exp=0000", p8); end
    n_vec++; if (st8 !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", st8); end
    n_vec++; if (p2 !== 4'h0) begin n_err++; $display("FAIL reset_p2 got=%h exp=0", p2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_w2;
    logic [3:0] prod;
    logic [3:0] exp;
    int lat;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        run2(2'(ai), 2'(bi), prod, lat);
        exp = 4'(ai * bi);
        n_vec++;
        if (prod !== exp) begin
          n_err++; $display("FAIL w2_prod %0dx%0d got=%b exp=%b", ai, bi, prod, exp);
        end
        n_vec++;
        if (lat !== 3) begin
          n_err++; $display("FAIL w2_latency %0dx%0d got=%0d exp=3", ai, bi, lat);
        end
      end
    end
    run2(2'd3, 2'd3, prod, lat);
    n_vec++; if (prod !== 4'b1001) begin n_err++; $display("FAIL w2_3x3 got=%b exp=1001", prod); end
  endtask

  task automatic test_corners_w8;
    logic [15:0] prod;
    int lat, busy_lo;
    logic acc_busy;
    for (int i = 0; i < 8; i++) begin
      run8(TA[i], TB[i], TS[i], prod, lat, acc_busy, busy_lo);
      n_vec++;
      if (prod !== TE[i]) begin
        n_err++; $display("FAIL w8_prod[%0d] %h*%h s=%b got=%h exp=%h", i, TA[i], TB[i], TS[i], prod, TE[i]);
      end
      n_vec++;
      if (lat !== 9) begin n_err++; $display("FAIL w8_latency[%0d] got=%0d exp=9", i, lat); end
      n_vec++;
      if (acc_busy !== 1'b1 || busy_lo !== 0) begin
        n_err++; $display("FAIL w8_busy[%0d] after_accept=%b low_cycles=%0d exp=1/0", i, acc_busy, busy_lo);
      end
      n_vec++;
      if (busy8 !== 1'b0) begin n_err++; $display("FAIL w8_busy_at_done[%0d] got=%b exp=0", i, busy8); end
    end
  endtask

  task automatic test_start_while_busy;
    int lat, extra;
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_vec++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL busy_during_ignored got=%b exp=1", busy8); end
    lat = 3;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL ignored_latency got=%0d exp=9", lat); end
    n_vec++; if (p8 !== 16'd200) begin n_err++; $display("FAIL ignored_prod got=%0d exp=200", p8); end
    // Re-issue while done is high: the FSM is already IDLE, so this is accepted on the next edge.
    a8 = 8'd5; b8 = 8'd6; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_vec++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy got=%b exp=1", busy8); end
    lat = 0;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
    n_vec++; if (p8 !== 16'd30) begin n_err++; $display("FAIL b2b_prod got=%0d exp=30", p8); end
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) extra++; end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL stray_done got=%0d exp=0", extra); end
    n_vec++; if (p8 !== 16'd30) begin n_err++; $display("FAIL p_hold got=%0d exp=30", p8); end
  endtask

  task automatic test_reset_mid_run;
    int lat, stray;
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd100; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
    n_vec++; if (p8 !== 16'h0000) begin n_err++; $display("FAIL midrst_p got=%h exp=0000", p8); end
    stray = 0;
    repeat (3) begin @(posedge clk); #1; if (done8) stray++; end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL midrst_done got=%0d exp=0", stray); end
    @(negedge clk);
    rst_n = 1'b1; a8 = 8'd12; b8 = 8'd12; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_vec++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL rst_start_accept got=%b exp=1", busy8); end
    lat = 0;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL post_rst_latency got=%0d exp=9", lat); end
    n_vec++; if (p8 !== 16'd144) begin n_err++; $display("FAIL post_rst_prod got=%0d exp=144", p8); end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic sm, acc_busy;
    logic signed [15:0] sa, sb;
    logic [15:0] ua, ub, exp, prod;
    int lat, busy_lo;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      sa = $signed(a); sb = $signed(b);
      ua = {8'h00, a}; ub = {8'h00, b};
      exp = sm ? 16'(sa * sb) : 16'(ua * ub);
      run8(a, b, sm, prod, lat, acc_busy, busy_lo);
      n_vec++;
      if (prod !== exp || lat !== 9) begin
        n_err++; $display("FAIL rand[%0d] %h*%h s=%b got=%h lat=%0d exp=%h lat=9", i, a, b, sm, prod, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_w2;
    test_corners_w8;
    test_start_while_busy;
    test_reset_mid_run;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
